// File: rtl/matrix_uart_printer.sv
// Formats a latched matrix of 8-bit unsigned values as decimal ASCII text and
// streams it, one byte per start/busy handshake, to a shared UART transmitter.
module matrix_uart_printer #(
  parameter int MAX_DIM = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [MAX_DIM*MAX_DIM*8-1:0] matrix_flat,
  input  logic [2:0]                   dim_m,
  input  logic [2:0]                   dim_n,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  output logic [7:0]                   tx_data,
  output logic                         tx_start,
  input  logic                         tx_busy
);

  localparam int MW = MAX_DIM * MAX_DIM * 8;
  localparam logic [2:0] MAX_D = 3'(MAX_DIM);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_LOAD  = 4'd1,
    S_FETCH = 4'd2,
    S_SEND  = 4'd3,
    S_HOLD  = 4'd4,
    S_WAIT  = 4'd5,
    S_NEXT  = 4'd6,
    S_DONE  = 4'd7,
    S_ERR   = 4'd8
  } state_t;

  state_t        state_r, next_state;
  logic [MW-1:0] mat_r;
  logic [2:0]    m_r, n_r;
  logic [2:0]    row_r, col_r, idx_r;
  logic [2:0]    row_s, col_s, idx_s;
  logic          busy_r, done_r, error_r, tx_start_r;
  logic [7:0]    tx_data_r;
  logic          busy_s, done_s, error_s, tx_start_s;
  logic [7:0]    tx_data_s;
  logic [7:0]    cur_v;
  logic          cur_last;

  function automatic logic [7:0] elem_at(input logic [MW-1:0] mat,
                                         input logic [2:0] r, input logic [2:0] c);
    logic [7:0] e;
    e = 8'h00;
    for (int i = 0; i < MAX_DIM * MAX_DIM; i++) begin
      if (i == int'(r) * MAX_DIM + int'(c)) begin
        e = mat[i*8 +: 8];
      end else begin
        e = e;
      end
    end
    return e;
  endfunction

  function automatic logic [1:0] num_digits(input logic [7:0] v);
    logic [1:0] nd;
    if (v >= 8'd100) begin
      nd = 2'd3;
    end else if (v >= 8'd10) begin
      nd = 2'd2;
    end else begin
      nd = 2'd1;
    end
    return nd;
  endfunction

  // Byte sequence of one element: significant digits, then a space or CR LF
  function automatic logic [7:0] seq_byte(input logic [7:0] v, input logic [2:0] idx,
                                          input logic last);
    logic [2:0] nd;
    logic [2:0] pos;
    logic [7:0] d;
    logic [7:0] b;
    nd  = {1'b0, num_digits(v)};
    pos = idx + 3'd3 - nd;
    case (pos)
      3'd0:    d = v / 8'd100;
      3'd1:    d = (v / 8'd10) % 8'd10;
      default: d = v % 8'd10;
    endcase
    if (idx < nd) begin
      b = 8'h30 + d;
    end else if (!last) begin
      b = 8'h20;
    end else if (idx == nd) begin
      b = 8'h0D;
    end else begin
      b = 8'h0A;
    end
    return b;
  endfunction

  function automatic logic [2:0] seq_len(input logic [7:0] v, input logic last);
    return {1'b0, num_digits(v)} + (last ? 3'd2 : 3'd1);
  endfunction

  assign cur_v    = elem_at(mat_r, row_r, col_r);
  assign cur_last = (col_r == n_r - 3'd1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state;
    end
  end

  // Next-state and byte-position selection
  always_comb begin
    next_state = state_r;
    row_s      = row_r;
    col_s      = col_r;
    idx_s      = idx_r;
    case (state_r)
      S_IDLE:  next_state = start ? S_LOAD : S_IDLE;
      S_LOAD: begin
        row_s = 3'd0;
        col_s = 3'd0;
        idx_s = 3'd0;
        if (dim_m == 3'd0 || dim_n == 3'd0 || dim_m > MAX_D || dim_n > MAX_D) begin
          next_state = S_ERR;
        end else begin
          next_state = S_FETCH;
        end
      end
      S_FETCH: next_state = S_SEND;
      S_SEND:  next_state = S_HOLD;
      S_HOLD:  next_state = S_WAIT;
      S_WAIT:  next_state = tx_busy ? S_WAIT : S_NEXT;
      S_NEXT: begin
        if (idx_r + 3'd1 < seq_len(cur_v, cur_last)) begin
          idx_s      = idx_r + 3'd1;
          next_state = S_SEND;
        end else if (!cur_last) begin
          idx_s      = 3'd0;
          col_s      = col_r + 3'd1;
          next_state = S_SEND;
        end else if (row_r != m_r - 3'd1) begin
          idx_s      = 3'd0;
          col_s      = 3'd0;
          row_s      = row_r + 3'd1;
          next_state = S_SEND;
        end else begin
          next_state = S_DONE;
        end
      end
      S_DONE:  next_state = S_IDLE;
      S_ERR:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Job capture and element/byte counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mat_r <= '0;
      m_r   <= 3'd0;
      n_r   <= 3'd0;
      row_r <= 3'd0;
      col_r <= 3'd0;
      idx_r <= 3'd0;
    end else begin
      if (state_r == S_LOAD) begin
        mat_r <= matrix_flat;
        m_r   <= dim_m;
        n_r   <= dim_n;
      end else begin
        mat_r <= mat_r;
        m_r   <= m_r;
        n_r   <= n_r;
      end
      row_r <= row_s;
      col_r <= col_s;
      idx_r <= idx_s;
    end
  end

  // Outputs derived from the upcoming state so they line up with it once registered
  always_comb begin
    busy_s     = (next_state != S_IDLE);
    done_s     = (next_state == S_DONE);
    error_s    = (next_state == S_ERR);
    tx_start_s = (next_state == S_SEND);
    if (next_state == S_SEND) begin
      tx_data_s = seq_byte(elem_at(mat_r, row_s, col_s), idx_s, (col_s == n_r - 3'd1));
    end else begin
      tx_data_s = tx_data_r;
    end
  end

  // Output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
      tx_start_r <= 1'b0;
      tx_data_r  <= 8'h00;
    end else begin
      busy_r     <= busy_s;
      done_r     <= done_s;
      error_r    <= error_s;
      tx_start_r <= tx_start_s;
      tx_data_r  <= tx_data_s;
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign error    = error_r;
  assign tx_start = tx_start_r;
  assign tx_data  = tx_data_r;

endmodule

// File: tb/tb_matrix_uart_printer.sv
// Directed/randomized bench for matrix_uart_printer with a UART responder model
// and a string-based reference of the expected text.
module tb_matrix_uart_printer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [199:0] matrix_flat = '0;
  logic [2:0]   dim_m = 3'd1;
  logic [2:0]   dim_n = 3'd1;
  logic         busy, done, error, tx_start;
  logic [7:0]   tx_data;
  logic         tx_busy = 1'b0;

  int errors = 0;
  int checks = 0;

  // responder/monitor state (written only by the responder process)
  logic [7:0] rxq[$];
  logic [7:0] held_byte = 8'h00;
  int         bcnt = 0;
  int         start_cnt = 0;
  int         done_cnt = 0;
  int         err_cnt = 0;
  int         viol = 0;

  // knobs (written only by the stimulus process)
  int         busy_lo = 10;
  int         busy_hi = 10;
  logic       hold_busy = 1'b0;

  logic [7:0] mat [5][5];
  string      exp_s;
  int         base, dbase, sbase, ebase;

  matrix_uart_printer #(.MAX_DIM(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .matrix_flat(matrix_flat),
    .dim_m(dim_m), .dim_n(dim_n), .busy(busy), .done(done), .error(error),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  // UART model: busy for a random number of cycles per byte, plus protocol monitor
  always @(posedge clk) begin
    if (tx_start) begin
      rxq.push_back(tx_data);
      held_byte <= tx_data;
      tx_busy   <= 1'b1;
      bcnt      <= $urandom_range(busy_hi, busy_lo);
      start_cnt <= start_cnt + 1;
      if (!busy || tx_busy) viol <= viol + 1;
    end else if (tx_busy) begin
      if (rst_n && tx_data !== held_byte) viol <= viol + 1;
      if (!hold_busy) begin
        if (bcnt <= 1) tx_busy <= 1'b0;
        else bcnt <= bcnt - 1;
      end
    end
    if (done) done_cnt <= done_cnt + 1;
    if (error) err_cnt <= err_cnt + 1;
    if (done && error) viol <= viol + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_job(input int m, input int n);
    matrix_flat = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        matrix_flat[(r*5+c)*8 +: 8] = mat[r][c];
    dim_m = 3'(m);
    dim_n = 3'(n);
    exp_s = "";
    for (int r = 0; r < m; r++) begin
      for (int c = 0; c < n; c++) begin
        exp_s = {exp_s, $sformatf("%0d", mat[r][c])};
        if (c < n - 1) exp_s = {exp_s, " "};
      end
      exp_s = {exp_s, $sformatf("%c%c", 8'h0d, 8'h0a)};
    end
  endtask

  task automatic start_job(input int m, input int n);
    load_job(m, n);
    base  = rxq.size();
    dbase = done_cnt;
    sbase = start_cnt;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("load_busy", busy, 1'b1);
    @(posedge clk); #1;
    chk("fetch_no_txs", tx_start, 1'b0);
    @(posedge clk); #1;
    chk("first_txs", tx_start, 1'b1);
  endtask

  task automatic finish_job(input string tag);
    logic prevb;
    int   fall, dk, bad, got, nbytes;
    prevb = tx_busy; fall = -100; dk = 0; got = 0; bad = 0;
    for (int k = 0; k < 30000; k++) begin
      @(posedge clk); #1;
      if (prevb && !tx_busy) fall = k;
      prevb = tx_busy;
      if (done === 1'b1) begin got = 1; dk = k; break; end
    end
    chk({tag, "_done_seen"}, got, 1);
    chk({tag, "_done_lat"}, dk - fall, 2);
    chk({tag, "_done_busy"}, busy, 1'b1);
    @(posedge clk); #1;
    chk({tag, "_idle_busy"}, busy, 1'b0);
    chk({tag, "_idle_done"}, done, 1'b0);
    nbytes = rxq.size() - base;
    chk({tag, "_nbytes"}, nbytes, exp_s.len());
    for (int i = 0; i < exp_s.len(); i++)
      if (base + i >= rxq.size() || rxq[base+i] !== exp_s[i]) bad++;
    chk({tag, "_bytes"}, bad, 0);
    chk({tag, "_done_cnt"}, done_cnt - dbase, 1);
    chk({tag, "_protocol"}, viol, 0);
  endtask

  task automatic err_job(input string tag, input int m, input int n);
    dim_m = 3'(m);
    dim_n = 3'(n);
    sbase = start_cnt; ebase = err_cnt; dbase = done_cnt;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk({tag, "_t1_busy"}, busy, 1'b1);
    chk({tag, "_t1_err"}, error, 1'b0);
    @(posedge clk); #1;
    chk({tag, "_t2_err"}, error, 1'b1);
    chk({tag, "_t2_done"}, done, 1'b0);
    @(posedge clk); #1;
    chk({tag, "_t3_busy"}, busy, 1'b0);
    chk({tag, "_t3_err"}, error, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk({tag, "_no_txs"}, start_cnt - sbase, 0);
    chk({tag, "_err_cnt"}, err_cnt - ebase, 1);
    chk({tag, "_no_done"}, done_cnt - dbase, 0);
  endtask

  initial begin
    int k, sb2, db2, ok;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_txs", tx_start, 1'b0);
    chk("rst_txd", tx_data, 8'h00);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // 2x3 directed, fixed 10-cycle busy
    for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) mat[r][c] = 8'd0;
    mat[0][0] = 8'd1; mat[0][1] = 8'd2; mat[0][2] = 8'd3;
    mat[1][0] = 8'd4; mat[1][1] = 8'd5; mat[1][2] = 8'd6;
    start_job(2, 3);
    finish_job("m2x3");

    mat[0][0] = 8'd255; mat[0][1] = 8'd10; mat[0][2] = 8'd100;
    start_job(1, 3);
    finish_job("m1x3");

    mat[0][0] = 8'd0;
    start_job(1, 1);
    finish_job("m1x1");

    err_job("dim_m0", 0, 3);
    err_job("dim_n6", 2, 6);
    err_job("dim_m7", 7, 1);

    // 5x5 all 200, random busy, inputs changed after capture
    busy_lo = 1; busy_hi = 20;
    for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) mat[r][c] = 8'd200;
    start_job(5, 5);
    for (int i = 0; i < 25; i++) matrix_flat[i*8 +: 8] = 8'($urandom);
    dim_m = 3'd1; dim_n = 3'd2;
    finish_job("m5x5");

    // random shapes and values
    busy_lo = 1; busy_hi = 6;
    for (int j = 0; j < 4; j++) begin
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 5; c++)
          mat[r][c] = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(12, 0)) : 8'($urandom);
      start_job($urandom_range(5, 1), $urandom_range(5, 1));
      finish_job("rand");
    end

    // stall with busy held high, extra starts ignored
    hold_busy = 1'b1;
    start_job(3, 4);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk) start = (i % 7 == 0);
    end
    start = 1'b0;
    #1;
    chk("stall_one_txs", start_cnt - sbase, 1);
    chk("stall_txd", tx_data, exp_s[0]);
    chk("stall_txbusy", tx_busy, 1'b1);
    chk("stall_busy", busy, 1'b1);
    hold_busy = 1'b0;
    finish_job("stall");

    // reset mid-job after the third byte
    start_job(4, 5);
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (rxq.size() >= base + 3) begin ok = 1; break; end
    end
    chk("rst3_reached", ok, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_txs", tx_start, 1'b0);
    chk("mid_rst_txd", tx_data, 8'h00);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_err", error, 1'b0);
    sb2 = start_cnt; db2 = done_cnt;
    repeat (10) @(posedge clk);
    k = 0;
    while (tx_busy && k < 100) begin @(posedge clk); k++; end
    #1;
    chk("mid_rst_quiet_txs", start_cnt - sb2, 0);
    chk("mid_rst_quiet_done", done_cnt - db2, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    start_job(4, 5);
    finish_job("after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
